// File: rtl/iob_acc_sampler_pkg.sv
// Shared types and default widths for the accumulator sampler.
// The FSM state encoding is used by the top module.
package iob_acc_sampler_pkg;
  localparam int DATA_W_DEF   = 21;
  localparam int PERIOD_W_DEF = 16;
  localparam int DROP_W_DEF   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/iob_acc_sampler_tick.sv
// Reloadable down-counter: latches max(period,1) on load, ticks for one cycle
// whenever the count reaches zero while enabled.
module iob_acc_sampler_tick #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);
  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_per;

  assign w_per = (period_i == '0) ? PERIOD_W'(1) : period_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_per <= PERIOD_W'(1);
      r_cnt <= '0;
    end else if (cke_i) begin
      if (load_i) begin
        r_per <= w_per;
        r_cnt <= w_per - PERIOD_W'(1);
      end else if (en_i) begin
        r_cnt <= (r_cnt == '0) ? r_per - PERIOD_W'(1) : r_cnt - PERIOD_W'(1);
      end
    end
  end

  assign tick_o = en_i && (r_cnt == '0);
endmodule

// File: rtl/iob_acc_sampler.sv
// Samples a free-running accumulator every P cycles and streams the deltas
// over valid/ready; samples that find the slot occupied are dropped and counted.
module iob_acc_sampler
  import iob_acc_sampler_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [DATA_W-1:0]   acc_i,
  output logic [DATA_W-1:0]   delta_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DROP_W-1:0]   drop_o,
  output logic                busy_o
);
  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_prev;
  logic [DATA_W-1:0]   r_delta;
  logic                r_valid;
  logic [DROP_W-1:0]   r_drop;
  logic                w_load;
  logic                w_run;
  logic                w_tick;
  logic                w_start;
  logic                w_samp;
  logic                w_accept;
  logic [DATA_W-1:0]   w_delta;

  assign w_run    = (r_state == ST_RUN);
  assign w_load   = start_i && (r_state == ST_IDLE);
  assign w_start  = cke_i && w_load;
  assign w_samp   = cke_i && w_tick;
  assign w_accept = cke_i && r_valid && ready_i;
  assign w_delta  = acc_i - r_prev;

  iob_acc_sampler_tick #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .load_i   (w_load),
    .en_i     (w_run),
    .period_i (period_i),
    .tick_o   (w_tick)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= ST_IDLE;
    else if (cke_i) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
      ST_RUN:  if (stop_i)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == ST_RUN);
  end

  // A sample may reuse the slot in the same cycle the consumer drains it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_prev  <= '0;
      r_delta <= '0;
      r_valid <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_start) begin
        r_prev <= acc_i;
        r_drop <= '0;
      end
      if (w_samp) begin
        r_prev <= acc_i;
        if (!r_valid || ready_i) begin
          r_delta <= w_delta;
          r_valid <= 1'b1;
        end else if (r_drop != '1) begin
          r_drop <= r_drop + DROP_W'(1);
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign delta_o = r_delta;
  assign valid_o = r_valid;
  assign drop_o  = r_drop;
endmodule

// File: doc/iob_acc_sampler.md
# iob_acc_sampler

Downstream stage for the accumulator: periodically samples the running accumulator value, computes the increment since the previous sample, and delivers each delta over a valid/ready interface. Turns a free-running total into a per-window rate stream, such as events per period, for a consumer that may apply backpressure. Samples that cannot be delivered are dropped and counted.

## Interface
- DATA_W, 21, width of the accumulator value and of the delta
- PERIOD_W, 16, width of the sampling-period input
- DROP_W, 8, width of the saturating dropped-sample counter

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  reset; asynchronous, active-low
- cke_i  in  1  clock enable; when 0, all state is frozen and ready_i is ignored
- start_i  in  1  single-cycle start pulse; ignored while busy
- stop_i  in  1  single-cycle stop pulse; ignored while idle
- period_i  in  PERIOD_W  sampling period in cycles, latched on start; 0 is treated as 1
- acc_i  in  DATA_W  accumulator value (the accumulator's data_o)
- delta_o  out  DATA_W  acc_i(now) − acc_i(previous sample), modulo 2^DATA_W
- valid_o  out  1  delta_o holds an undelivered sample
- ready_i  in  1  consumer accepts delta_o when valid_o && ready_i
- drop_o  out  DROP_W  count of samples lost to backpressure; saturates at all-ones
- busy_o  out  1  1 while in RUN

## Operation
- FSM, two states: IDLE and RUN.
- IDLE: start_i latches the period as P = max(period_i, 1), sets prev <= acc_i, loads cnt <= P−1, clears drop_o, and moves to RUN. A pending valid_o is kept.
- RUN:
  - Each enabled cycle with cnt ≠ 0: cnt decrements.
  - With cnt == 0 (the sample edge): compute delta = acc_i − prev (wrap-around subtraction, DATA_W bits, no sign), set prev <= acc_i, reload cnt <= P−1.
  - Delivery at a sample edge:
    - Slot empty, or slot consumed this same cycle (valid_o && ready_i): delta_o <= delta and valid_o <= 1.
    - Otherwise the new sample is discarded; delta_o is left unchanged; drop_o increments with saturation.
- stop_i in RUN moves to IDLE at the next edge.
  - If that edge is also a sample edge, the sample is taken first.
  - A pending valid_o remains until it is consumed.
- start_i in RUN is ignored. stop_i in IDLE is ignored. start_i and stop_i together in IDLE: start wins.
- Handshake:
  - delta_o is stable while valid_o && !ready_i.
  - valid_o falls on accept unless a new sample loads in the same cycle.
  - valid_o never depends combinationally on ready_i.
- Reset values: valid_o=0, delta_o=0, drop_o=0, busy_o=0; state IDLE; prev=0; cnt=0.
- Reset asserted mid-operation clears everything immediately; a pending sample is lost.

## Timing
- start_i is registered at edge E0. Sample edges fall at E0+P, E0+2P, …
- Each delta uses the acc_i value present just before its sample edge. valid_o is high in the cycle after that edge.
- Latency from sample edge to valid_o is 1 cycle. Throughput is one sample per P cycles.
- With P=1 and ready_i held high, valid_o stays high continuously and delta_o updates every cycle.
- All outputs are registered.
- cke_i=0 stretches every interval by the number of disabled cycles.

## Structure
- Shared package iob_acc_sampler_pkg holds:
  - state encoding (IDLE=0, RUN=1)
  - default widths for DATA_W, PERIOD_W and DROP_W
- One sub-module, iob_acc_sampler_tick: a reloadable down-counter with cke_i, load, and period inputs and a one-cycle tick output at cnt==0.
- The FSM, the subtractor, the output slot and the drop counter stay in the top module.

## Test plan
- Reset and idle: hold arst_n_i low for 3 cycles, then release. Required: all outputs 0. start_i, P=4, acc_i ramping +1 per cycle, ready_i=1 → valid_o pulses every 4 cycles with delta_o=4.
- Wrap-around: DATA_W=21, prev=0x1FFFFE, acc_i=0x000003 at the sample edge → delta_o=5.
- Backpressure: P=2, ready_i=0 for 10 cycles → the first delta is held stable and drop_o=4. Then raise ready_i → accepted; the next sample loads normally.
- Simultaneous accept and sample: P=1, ready_i=1, acc_i steps +3 each cycle → valid_o continuously 1, delta_o=3 every cycle, drop_o=0.
- Stop on the sample edge: stop_i on a sample edge with ready_i=0 → that sample is delivered and busy_o falls. valid_o stays high until ready_i=1, then falls.
- Async reset in RUN with valid_o=1 → valid_o, delta_o, drop_o and busy_o clear immediately. period_i=0 on the next start → behaves as P=1.
